truth_table_checker: RTL and testbench
======================================

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 SHALL have parameter N_IN, default 3: number of DUT inputs, range 1..8.
REQ-002 SHALL have parameter EXPECTED, default 8'h96 (width 2**N_IN): expected output for each vector; bit i applies to vector value i.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1: cycles each vector is held before sampling, range 1..255.
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  begin a sweep; sampled only in IDLE.
REQ-008 abort  input  1  cancel a sweep in progress; synchronous.
REQ-009 dut_out  input  1  combinational output of the device under test.
REQ-010 dut_in  output  N_IN  vector driven to the device under test.
REQ-011 busy  output  1  high in DRIVE and CHECK.
REQ-012 done  output  1  one-cycle pulse when a sweep completes.
REQ-013 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-014 fail_count  output  N_IN+1  mismatches in the current or last sweep.
REQ-015 first_fail_valid  output  1  at least one mismatch has been captured.
REQ-016 first_fail_vec  output  N_IN  lowest vector value that mismatched.

Function
REQ-017 SHALL implement FSM states IDLE, DRIVE, CHECK, DONE.
REQ-018 IDLE, start=1: go to DRIVE with dut_in=0, and clear fail_count, pass, first_fail_valid and first_fail_vec.
REQ-019 IDLE, start=0: remain in IDLE, holding dut_in and all results.
REQ-020 DRIVE: hold dut_in for exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-021 CHECK: compare dut_out with EXPECTED[dut_in] for one cycle.
- Mismatch: increment fail_count.
- Mismatch with first_fail_valid=0: set first_fail_valid and latch first_fail_vec=dut_in.
REQ-022 CHECK, dut_in < 2**N_IN-1: increment dut_in and go to DRIVE.
REQ-023 CHECK, dut_in = 2**N_IN-1: go to DONE without wrapping dut_in.
REQ-024 DONE: assert done for one cycle, set pass=(fail_count==0) including the final CHECK result, then go to IDLE.
REQ-025 Per-vector cost SHALL be SETTLE_CYCLES+1 cycles.
REQ-026 done SHALL be high exactly 2**N_IN*(SETTLE_CYCLES+1)+1 cycles after the start-accepting edge.
REQ-027 start outside IDLE, including in DONE, SHALL be ignored.
REQ-028 abort in DRIVE or CHECK: go to IDLE at the next edge.
- done not pulsed; pass stays 0.
- fail_count and first_fail_* keep their partial values.
- That CHECK's comparison is discarded.
REQ-029 abort has priority over all other transitions; abort in IDLE or DONE has no effect.
REQ-030 fail_count SHALL never overflow; its maximum is 2**N_IN.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, dut_in=0, busy=0, done=0, pass=0, fail_count=0, first_fail_valid=0, first_fail_vec=0.
REQ-032 Reset mid-sweep SHALL abandon the sweep with no done pulse.
REQ-033 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-034 State encodings (2-bit) and the width helper for 2**N_IN SHALL live in shared package tt_check_pkg.
REQ-035 The settle counter SHALL be sub-module tt_settle_timer (load, count down, expire flag); all other logic stays in truth_table_checker.

Verification
REQ-036 Defaults, DUT model = 3-input XOR, start pulse:
- dut_in sweeps 0..7, each held 2 cycles.
- done 17 cycles after start, pass=1, fail_count=0, first_fail_valid=0.
REQ-037 Defaults, DUT model = XOR with output forced 1 on vector 3'b011:
- pass=0, fail_count=1, first_fail_vec=3'b011.
REQ-038 N_IN=4, SETTLE_CYCLES=3, EXPECTED=16'h0000, DUT constant 1:
- done after 65 cycles, fail_count=16, first_fail_vec=0.
REQ-039 Defaults, abort during DRIVE of vector 5 with a fault on vector 2:
- Return to IDLE, no done, fail_count=1, first_fail_vec=2.
- A new start then clears all results.
REQ-040 Defaults, rst_n pulled low mid-CHECK:
- All outputs zero immediately, no done.
- start on the cycle after release begins a sweep from vector 0.
REQ-041 Defaults, start held high through a sweep and during DONE:
- Exactly one sweep per IDLE entry; the second sweep begins the cycle after DONE.

Source files
------------

// File: rtl/tt_check_pkg.sv
// Shared FSM encodings and sizing helpers for the truth-table sweep checker.
package tt_check_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int SETTLE_W = 8;

  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Down-counter that measures how long each vector is held before sampling.
module tt_settle_timer
  import tt_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= SETTLE_W'(SETTLE_CYCLES);
    end else if (run && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Expiry on the last held cycle, so DRIVE lasts exactly SETTLE_CYCLES cycles.
  assign expired = (cnt == SETTLE_W'(1));

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector into an external combinational DUT and counts
// mismatches against the expected truth table.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int N_IN = 3,
  parameter logic [vec_count(N_IN)-1:0] EXPECTED = 8'h96,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  logic [1:0] state;
  logic       settle_load;
  logic       settle_run;
  logic       settle_expired;
  logic       last_vec;
  logic       mismatch;

  assign last_vec = &dut_in;
  assign mismatch = (dut_out != EXPECTED[dut_in]);
  assign busy     = (state == ST_DRIVE) || (state == ST_CHECK);

  // The timer is reloaded on every entry into DRIVE.
  assign settle_load = ((state == ST_IDLE) && start) ||
                       ((state == ST_CHECK) && !abort && !last_vec);
  assign settle_run  = (state == ST_DRIVE);

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (settle_load),
    .run    (settle_run),
    .expired(settle_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      dut_in           <= '0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state            <= ST_DRIVE;
            dut_in           <= '0;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
          end
        end
        ST_DRIVE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (settle_expired) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // An abort here discards this vector's comparison entirely.
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            if (mismatch) begin
              fail_count <= fail_count + 1'b1;
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_vec   <= dut_in;
              end
            end
            if (last_vec) begin
              state <= ST_DONE;
            end else begin
              dut_in <= dut_in + 1'b1;
              state  <= ST_DRIVE;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          pass  <= (fail_count == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker with a sweep-timeline reference model.
module tb_truth_table_checker;

  localparam int N_A = 3;
  localparam int S_A = 1;
  localparam int T_A = (1 << N_A) * (S_A + 1);
  localparam logic [7:0] EXP_A = 8'h96;
  localparam int N_B = 4;
  localparam int S_B = 3;
  localparam logic [15:0] EXP_B = 16'h0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start_a, abort_a, dut_out_a, busy_a, done_a, pass_a, ffv_a;
  logic [2:0] dut_in_a, ffvec_a;
  logic [3:0] fc_a;
  logic       start_b, abort_b, dut_out_b, busy_b, done_b, pass_b, ffv_b;
  logic [3:0] dut_in_b, ffvec_b;
  logic [4:0] fc_b;
  logic       fault_en;
  logic [2:0] fault_vec;

  // Device models: 3-input XOR with an optional stuck vector, and a constant 1.
  assign dut_out_a = (^dut_in_a) ^ (fault_en && dut_in_a == fault_vec);
  assign dut_out_b = 1'b1;

  truth_table_checker #(.N_IN(N_A), .EXPECTED(EXP_A), .SETTLE_CYCLES(S_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .dut_out(dut_out_a),
    .dut_in(dut_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_count(fc_a), .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a));

  truth_table_checker #(.N_IN(N_B), .EXPECTED(EXP_B), .SETTLE_CYCLES(S_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .dut_out(dut_out_b),
    .dut_in(dut_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fc_b), .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: position within the sweep timeline (-1 = idle), plus results.
  int   m_pos = -1;
  int   m_vec = 0;
  int   m_fc = 0;
  int   m_ffvec = 0;
  logic m_ffv = 1'b0;
  logic m_pass = 1'b0;

  function automatic logic model_out(input int v);
    return (($countones(v) % 2) == 1) ^ (fault_en && v == int'(fault_vec));
  endfunction

  function automatic logic expected_bit(input int v);
    return ((EXP_A >> v) & 8'h01) != 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int old_pos;
    int new_pos;
    int v;
    if (!rst_n) begin
      m_pos <= -1; m_vec <= 0; m_fc <= 0; m_ffvec <= 0; m_ffv <= 1'b0; m_pass <= 1'b0;
    end else begin
      old_pos = m_pos;
      if (old_pos >= 0 && old_pos < T_A && abort_a) begin
        new_pos = -1;
      end else if ((old_pos < 0 || old_pos > T_A) && start_a) begin
        new_pos = 0;
        m_fc <= 0; m_ffv <= 1'b0; m_ffvec <= 0; m_pass <= 1'b0;
      end else if (old_pos >= 0 && old_pos <= T_A) begin
        new_pos = old_pos + 1;
      end else begin
        new_pos = -1;
      end
      if (old_pos >= 0 && old_pos < T_A && !abort_a && (old_pos % (S_A + 1)) == S_A) begin
        v = old_pos / (S_A + 1);
        if (model_out(v) != expected_bit(v)) begin
          m_fc <= m_fc + 1;
          if (!m_ffv) begin
            m_ffv <= 1'b1;
            m_ffvec <= v;
          end
        end
      end
      if (old_pos == T_A) m_pass <= (m_fc == 0);
      if (new_pos >= 0 && new_pos < T_A) m_vec <= new_pos / (S_A + 1);
      m_pos <= new_pos;
    end
  end

  always @(negedge clk) begin
    check("cyc_dut_in", 32'(dut_in_a), 32'(m_vec));
    check("cyc_busy", 32'(busy_a), 32'(m_pos >= 0 && m_pos < T_A));
    check("cyc_done", 32'(done_a), 32'(m_pos == T_A + 1));
    check("cyc_pass", 32'(pass_a), 32'(m_pass));
    check("cyc_fail_count", 32'(fc_a), 32'(m_fc));
    check("cyc_ffv", 32'(ffv_a), 32'(m_ffv));
    check("cyc_ffvec", 32'(ffvec_a), 32'(m_ffvec));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  // Count edges from the accepting edge until done is seen (bounded).
  task automatic wait_done_a(output int lat);
    lat = 0;
    while (!done_a && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int seen;

  initial begin
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    fault_en = 1'b0; fault_vec = 3'd0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_dut_in", 32'(dut_in_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_pass", 32'(pass_a), 0);
    check("rst_fail_count", 32'(fc_a), 0);
    check("rst_ffv", 32'(ffv_a), 0);
    check("rst_ffvec", 32'(ffvec_a), 0);
    check("rst_b_fail_count", 32'(fc_b), 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Clean sweep, started on the first edge after reset release.
    pulse_start_a();
    check("first_edge_busy", 32'(busy_a), 1);
    wait_done_a(lat);
    check("clean_latency", 32'(lat), 17);
    check("clean_pass", 32'(pass_a), 1);
    check("clean_fail_count", 32'(fc_a), 0);
    check("clean_ffv", 32'(ffv_a), 0);
    tick();

    // Single fault on vector 3.
    fault_en = 1'b1; fault_vec = 3'd3;
    pulse_start_a();
    wait_done_a(lat);
    check("fault3_latency", 32'(lat), 17);
    check("fault3_pass", 32'(pass_a), 0);
    check("fault3_fail_count", 32'(fc_a), 1);
    check("fault3_ffv", 32'(ffv_a), 1);
    check("fault3_ffvec", 32'(ffvec_a), 3);
    tick();

    // Abort during DRIVE of vector 5 with a fault on vector 2.
    fault_vec = 3'd2;
    pulse_start_a();
    repeat (10) tick();
    check("abort_pre_vec", 32'(dut_in_a), 5);
    check("abort_pre_busy", 32'(busy_a), 1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("abort_busy", 32'(busy_a), 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_a) seen++;
      tick();
    end
    check("abort_no_done", 32'(seen), 0);
    check("abort_fail_count", 32'(fc_a), 1);
    check("abort_ffvec", 32'(ffvec_a), 2);
    check("abort_pass", 32'(pass_a), 0);
    fault_en = 1'b0;
    pulse_start_a();
    check("restart_fail_count", 32'(fc_a), 0);
    check("restart_ffv", 32'(ffv_a), 0);
    check("restart_ffvec", 32'(ffvec_a), 0);
    check("restart_dut_in", 32'(dut_in_a), 0);
    wait_done_a(lat);
    check("restart_latency", 32'(lat), 17);
    check("restart_pass", 32'(pass_a), 1);
    tick();

    // Reset during the CHECK of vector 3.
    pulse_start_a();
    repeat (7) tick();
    check("midchk_vec", 32'(dut_in_a), 3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dut_in", 32'(dut_in_a), 0);
    check("midrst_busy", 32'(busy_a), 0);
    check("midrst_done", 32'(done_a), 0);
    check("midrst_fail_count", 32'(fc_a), 0);
    tick();
    rst_n = 1'b1;
    pulse_start_a();
    check("postrst_busy", 32'(busy_a), 1);
    check("postrst_dut_in", 32'(dut_in_a), 0);
    wait_done_a(lat);
    check("postrst_latency", 32'(lat), 17);
    tick();

    // Start held high through a sweep and its DONE cycle.
    start_a = 1'b1;
    tick();
    wait_done_a(lat);
    check("held_latency", 32'(lat), 17);
    tick();
    check("held_done_one_cycle", 32'(done_a), 0);
    check("held_second_busy", 32'(busy_a), 1);
    check("held_second_vec", 32'(dut_in_a), 0);
    start_a = 1'b0;
    wait_done_a(lat);
    check("held_second_latency", 32'(lat), 17);
    repeat (3) tick();
    check("held_no_third", 32'(busy_a), 0);

    // Wider instance: every vector mismatches.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 500) begin
      tick();
      lat++;
    end
    check("b_latency", 32'(lat), 65);
    check("b_fail_count", 32'(fc_b), 16);
    check("b_ffv", 32'(ffv_b), 1);
    check("b_ffvec", 32'(ffvec_b), 0);
    check("b_pass", 32'(pass_b), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
